intersection_controller: RTL
============================

Name: intersection_controller

Overview:
Sequences a two-approach intersection (north-south, east-west) through green, yellow and all-red clearance phases with programmable durations. Latches pedestrian crossing requests and grants a walk window at the start of the matching green. Sits above the per-approach lamp drivers and owns all timing. It guarantees that conflicting approaches are never non-red at the same time.

Parameters:
GREEN_CYCLES, 20, green phase length in clk cycles (>=1)
YELLOW_CYCLES, 7, yellow phase length (>=1)
ALLRED_CYCLES, 2, all-red clearance length (>=1)
WALK_CYCLES, 8, walk window length, counted from green entry (1..GREEN_CYCLES)
CNT_W, 8, phase counter width; must hold max(all durations)-1

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  run intersection; low = return safely to all-red idle
ped_req_ns  input  1  pedestrian request for NS crossing; sampled each cycle, level or pulse
ped_req_ew  input  1  pedestrian request for EW crossing
ns_red  output  1  NS red lamp
ns_yellow  output  1  NS yellow lamp
ns_green  output  1  NS green lamp
ew_red  output  1  EW red lamp
ew_yellow  output  1  EW yellow lamp
ew_green  output  1  EW green lamp
walk_ns  output  1  NS walk signal
walk_ew  output  1  EW walk signal
ped_pend_ns  output  1  NS request latched, not yet served
ped_pend_ew  output  1  EW request latched, not yet served
phase  output  3  state code: 0 IDLE, 1 NS_GRN, 2 NS_YEL, 3 CLR_A, 4 EW_GRN, 5 EW_YEL, 6 CLR_B

Behaviour:
- Async reset: state=IDLE, counter=0, pending flags=0. ns_red=ew_red=1; all other lamps, walk, pend and phase=0.
- All outputs are registered and change only on clk rising edge, or asynchronously on reset.
- Counter: loaded with DURATION-1 on entry to a timed state and decrements each cycle. The state exits on the edge where the counter is 0, so each phase lasts exactly DURATION cycles.
- IDLE: both approaches red. On an edge with enable=1, go to NS_GRN.
- NS_GRN (GREEN_CYCLES) -> NS_YEL (YELLOW_CYCLES) -> CLR_A (ALLRED_CYCLES) -> EW_GRN -> EW_YEL -> CLR_B -> NS_GRN.
- Lamps: exactly one lamp per approach is on. The approach not named by the current phase is red. CLR_A, CLR_B and IDLE show both approaches red.
- enable low during xx_GRN: the next edge goes to xx_YEL (green truncated), with a full yellow.
- enable low during yellow or clearance: the phase completes normally.
- enable low at the end of CLR_A or CLR_B: go to IDLE instead of the next green.
- enable high again in IDLE: restart at NS_GRN.
- Pedestrian latch: ped_pend_x is set on any edge where ped_req_x=1.
- On entry to x_GRN, if pend_x (or ped_req_x the same cycle) is set: clear pend_x, and assert walk_x for the first WALK_CYCLES cycles of that green.
- A request arriving during x_GRN after entry stays pending for the next x_GRN.
- Set and clear in the same cycle: the clear wins only for a request already pending or sampled at the entry edge. A request sampled on a later edge re-sets the flag.
- walk_x deasserts immediately if the green is truncated by enable low. It is never asserted outside x_GRN.
- Pending flags persist through IDLE.
- Safety invariant: never (ns_green|ns_yellow) && (ew_green|ew_yellow).
- Illegal state code: recover to IDLE on the next edge.

Test Plan:
- Reset held, then released with enable=0 for 10 cycles -> ns_red=ew_red=1, phase=0, walk=0 throughout.
- enable=1 continuously from cycle 0 -> NS_GRN 20 cycles, NS_YEL 7, CLR_A 2, EW_GRN 20, EW_YEL 7, CLR_B 2. Period is 58 cycles; the invariant holds every cycle.
- 1-cycle ped_req_ew pulse during NS_GRN -> ped_pend_ew=1 until EW_GRN entry. walk_ew=1 for exactly 8 cycles, then 0; pend cleared.
- ped_req_ns pulse at NS_GRN cycle 10 -> no walk in this green. pend_ns stays 1 and walk_ns fires at the next NS_GRN.
- enable dropped at NS_GRN cycle 5 -> NS_YEL on the next edge for 7 cycles, CLR_A 2 cycles, then IDLE. EW is never green; walk_ns drops with green.
- Async reset asserted mid EW_YEL -> all outputs go to reset values without a clock edge. After release with enable=1, the sequence restarts at NS_GRN.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: green/yellow/all-red phases with
// programmable durations, pedestrian request latching and walk windows.
//  state    | meaning
//  IDLE     | both approaches red, waiting for enable
//  NS_GRN   | north-south green, EW red
//  NS_YEL   | north-south yellow, EW red
//  CLR_A    | all-red clearance before EW green
//  EW_GRN   | east-west green, NS red
//  EW_YEL   | east-west yellow, NS red
//  CLR_B    | all-red clearance before NS green
module intersection_controller #(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 7,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       ped_pend_ns,
  output logic       ped_pend_ew,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NS_GRN = 3'd1,
    S_NS_YEL = 3'd2,
    S_CLR_A  = 3'd3,
    S_EW_GRN = 3'd4,
    S_EW_YEL = 3'd5,
    S_CLR_B  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GRN_LD   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YEL_LD   = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_LD   = CNT_W'(ALLRED_CYCLES - 1);
  // Walk stays on while the green down-counter is at or above this value.
  localparam logic [CNT_W-1:0] WALK_MIN = CNT_W'(GREEN_CYCLES - WALK_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic             walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic [5:0]       lamp_q, lamp_d;
  logic             tc, enter_ns, enter_ew;

  always_comb begin
    state_d = state_q;
    tc      = (cnt_q == '0);
    cnt_d   = tc ? '0 : cnt_q - 1'b1;
    case (state_q)
      S_IDLE: if (enable) begin
        state_d = S_NS_GRN;
        cnt_d   = GRN_LD;
      end
      S_NS_GRN: if (!enable || tc) begin
        state_d = S_NS_YEL;
        cnt_d   = YEL_LD;
      end
      S_NS_YEL: if (tc) begin
        state_d = S_CLR_A;
        cnt_d   = RED_LD;
      end
      S_CLR_A: if (tc) begin
        state_d = enable ? S_EW_GRN : S_IDLE;
        cnt_d   = enable ? GRN_LD : '0;
      end
      S_EW_GRN: if (!enable || tc) begin
        state_d = S_EW_YEL;
        cnt_d   = YEL_LD;
      end
      S_EW_YEL: if (tc) begin
        state_d = S_CLR_B;
        cnt_d   = RED_LD;
      end
      S_CLR_B: if (tc) begin
        state_d = enable ? S_NS_GRN : S_IDLE;
        cnt_d   = enable ? GRN_LD : '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    enter_ns = (state_d == S_NS_GRN) && (state_q != S_NS_GRN);
    enter_ew = (state_d == S_EW_GRN) && (state_q != S_EW_GRN);

    // A request sampled on the entry edge is served by this green, not latched.
    pend_ns_d = enter_ns ? 1'b0 : (pend_ns_q | ped_req_ns);
    pend_ew_d = enter_ew ? 1'b0 : (pend_ew_q | ped_req_ew);
    walk_ns_d = enter_ns ? (pend_ns_q | ped_req_ns)
                         : (walk_ns_q && (state_d == S_NS_GRN) && (cnt_d >= WALK_MIN));
    walk_ew_d = enter_ew ? (pend_ew_q | ped_req_ew)
                         : (walk_ew_q && (state_d == S_EW_GRN) && (cnt_d >= WALK_MIN));

    lamp_d = {3'b100, 3'b100};
    case (state_d)
      S_NS_GRN: lamp_d = {3'b001, 3'b100};
      S_NS_YEL: lamp_d = {3'b010, 3'b100};
      S_EW_GRN: lamp_d = {3'b100, 3'b001};
      S_EW_YEL: lamp_d = {3'b100, 3'b010};
      default:  lamp_d = {3'b100, 3'b100};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      lamp_q    <= {3'b100, 3'b100};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_ns_q <= pend_ns_d;
      pend_ew_q <= pend_ew_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
      lamp_q    <= lamp_d;
    end
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamp_q;
  assign walk_ns     = walk_ns_q;
  assign walk_ew     = walk_ew_q;
  assign ped_pend_ns = pend_ns_q;
  assign ped_pend_ew = pend_ew_q;
  assign phase       = state_q;

endmodule
